// File: rtl/chacha_uart_rx_fifo_pkg.sv
// Shared types, parity-mode encodings and helpers for the ChaCha UART receiver.
package chacha_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // A FIFO entry is {parity_err, frame_err, data}.
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

    // Characters are at most 9 bits; narrower ones are zero-extended, which leaves the XOR unchanged.
    function automatic logic xor9(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/chacha_uart_rx_fifo_if.sv
// Valid/ready character stream from the receiver FIFO to the command parser.
interface chacha_uart_rx_fifo_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data;
    logic                 frame_err;
    logic                 parity_err;
    logic                 valid;
    logic                 ready;

    modport master (output data, frame_err, parity_err, valid, input ready);
    modport slave  (input data, frame_err, parity_err, valid, output ready);
endinterface

// File: rtl/chacha_uart_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module chacha_uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags, head word and accepted-operation strobes.
    always_comb begin
        full      = (count_r == LW'(DEPTH));
        empty     = (count_r == {LW{1'b0}});
        level     = count_r;
        head      = mem_r[rd_ptr_r];
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
    end

    // Storage write.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers (wrap naturally at a power-of-two depth) and occupancy.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/chacha_uart_rx_fifo.sv
// UART receiver front end: synchroniser, oversampling tick, deframing FSM and character FIFO.
module chacha_uart_rx_fifo
    import chacha_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              resetb,
    input  logic                              cfg_en,
    input  logic [DIV_WIDTH-1:0]              cfg_div,
    input  logic [1:0]                        cfg_parity,
    input  logic                              rx_i,
    chacha_uart_rx_fifo_if.master             m,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              ovr_flag,
    input  logic                              ovr_clr
);
    localparam int EW = entry_width(DATA_BITS);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic [DIV_WIDTH-1:0] div_cnt_r;
    logic                 tick_s;
    logic                 sync1_r, sync2_r, prev_r;
    logic                 fall_s;
    rx_state_t            state_r;
    logic [SW-1:0]        samp_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 par_odd_r;
    logic                 par_err_r;
    logic                 sample_s;
    logic                 par_on_s;
    logic                 par_bad_s;
    logic                 push_s;
    logic [EW-1:0]        push_data_s;
    logic                 pop_s;
    logic [EW-1:0]        head_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 ovr_r;

    // Tick strobe and per-bit decode of the current sample point.
    always_comb begin
        if (cfg_en && (div_cnt_r >= cfg_div)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        fall_s      = prev_r & ~sync2_r;
        sample_s    = tick_s & (samp_cnt_r == FULL_LAST);
        par_on_s    = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        par_bad_s   = (xor9(9'(shreg_r)) ^ sync2_r) != par_odd_r;
        push_s      = (state_r == STOP) & sample_s;
        push_data_s = {par_err_r, ~sync2_r, shreg_r};
    end

    // Tick divider, parked at zero while the receiver is disabled.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_cnt_r <= {DIV_WIDTH{1'b0}};
        end else if (!cfg_en || tick_s) begin
            div_cnt_r <= {DIV_WIDTH{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
        end
    end

    // Two-flop synchroniser plus one delayed copy for edge detection; idle line is high.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Deframing FSM; arming needs a real 1->0 edge so a held break never re-arms.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r    <= IDLE;
            samp_cnt_r <= {SW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            shreg_r    <= {DATA_BITS{1'b0}};
            par_odd_r  <= 1'b0;
            par_err_r  <= 1'b0;
        end else if (!cfg_en) begin
            state_r    <= IDLE;
            samp_cnt_r <= {SW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        state_r    <= START;
                        samp_cnt_r <= {SW{1'b0}};
                        bit_cnt_r  <= {BW{1'b0}};
                        par_err_r  <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (samp_cnt_r == HALF_LAST) begin
                            samp_cnt_r <= {SW{1'b0}};
                            state_r    <= sync2_r ? IDLE : DATA;
                        end else begin
                            samp_cnt_r <= samp_cnt_r + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        samp_cnt_r <= sample_s ? {SW{1'b0}} : samp_cnt_r + SW'(1);
                    end
                    if (sample_s) begin
                        shreg_r <= {sync2_r, shreg_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            par_odd_r <= (cfg_parity == PAR_ODD);
                            state_r   <= par_on_s ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        samp_cnt_r <= sample_s ? {SW{1'b0}} : samp_cnt_r + SW'(1);
                    end
                    if (sample_s) begin
                        par_err_r <= par_bad_s;
                        state_r   <= STOP;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        samp_cnt_r <= sample_s ? {SW{1'b0}} : samp_cnt_r + SW'(1);
                    end
                    if (sample_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    chacha_uart_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetb    (resetb),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .level     (fifo_level),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Sticky overrun: a dropped character outranks a coincident clear.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ovr_r <= 1'b0;
        end else if (push_s && full_s && !pop_s) begin
            ovr_r <= 1'b1;
        end else if (ovr_clr) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    // Stream side; the head word is masked so an empty FIFO presents all zeros.
    always_comb begin
        pop_s    = m.ready & ~empty_s;
        m.valid  = ~empty_s;
        ovr_flag = ovr_r;
        if (empty_s) begin
            m.data       = {DATA_BITS{1'b0}};
            m.frame_err  = 1'b0;
            m.parity_err = 1'b0;
        end else begin
            m.data       = head_s[DATA_BITS-1:0];
            m.frame_err  = head_s[DATA_BITS];
            m.parity_err = head_s[DATA_BITS+1];
        end
    end
endmodule

// File: tb/tb_chacha_uart_rx_fifo.sv
// Self-checking bench for chacha_uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_chacha_uart_rx_fifo;
    import chacha_uart_pkg::*;

    logic        clk = 1'b0;
    logic        resetb;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic        rx;
    logic [3:0]  fifo_level;
    logic        ovr_flag;
    logic        ovr_clr;

    chacha_uart_rx_fifo_if #(.DATA_BITS(8)) m ();

    chacha_uart_rx_fifo #(
        .DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16), .FIFO_DEPTH(8)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .cfg_en     (cfg_en),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .rx_i       (rx),
        .m          (m.master),
        .fifo_level (fifo_level),
        .ovr_flag   (ovr_flag),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       pbit;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t       vecs [8];
    logic [9:0] sb_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic line_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Drives one frame, one bit per 16 negedges; the stop sample lands on posedge 16*s+11.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                              input logic sb, input logic chk_lat, input logic pop_mid,
                              input int rst_at, input int en_at);
        logic [10:0] bits;
        logic [9:0]  exp_head;
        int          nb;
        int          s;
        bits      = 11'd0;
        bits[8:1] = d;
        nb        = 9;
        if (pm == PAR_EVEN || pm == PAR_ODD) begin
            bits[9] = pb;
            nb      = 10;
        end
        bits[nb] = sb;
        s        = nb;
        nb       = nb + 1;
        for (int j = 0; j < 16 * nb; j++) begin
            @(negedge clk);
            if (chk_lat && j == 16 * s + 10) check("valid_before_push", 32'(m.valid), 32'd0);
            if (chk_lat && j == 16 * s + 11) check("valid_after_push", 32'(m.valid), 32'd1);
            if (pop_mid && j == 16 * s + 10) begin
                exp_head = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
                check("full_pushpop_head", 32'({m.parity_err, m.frame_err, m.data}), 32'(exp_head));
                m.ready = 1'b1;
            end
            if (pop_mid && j == 16 * s + 11) m.ready = 1'b0;
            if (j == rst_at) begin
                resetb = 1'b0;
                rx     = 1'b1;
                repeat (3) @(negedge clk);
                resetb = 1'b1;
                return;
            end
            if (j == en_at) cfg_en = 1'b0;
            rx = bits[j / 16];
        end
    endtask

    task automatic pop_check(input string name);
        logic [9:0] exp_head;
        int waited = 0;
        while (!m.valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!m.valid) begin
            check({name, "_timeout"}, 32'(m.valid), 32'd1);
        end else if (sb_q.size() == 0) begin
            check({name, "_unexpected"}, 32'(m.valid), 32'd0);
        end else begin
            exp_head = sb_q.pop_front();
            check(name, 32'({m.parity_err, m.frame_err, m.data}), 32'(exp_head));
            m.ready = 1'b1;
            @(negedge clk);
            m.ready = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h03, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};

        resetb = 1'b0; cfg_en = 1'b0; cfg_div = 16'd0; cfg_parity = 2'b00;
        rx = 1'b1; ovr_clr = 1'b0; m.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(m.valid), 32'd0);
        check("rst_data", 32'(m.data), 32'd0);
        check("rst_fe", 32'(m.frame_err), 32'd0);
        check("rst_pe", 32'(m.parity_err), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovr", 32'(ovr_flag), 32'd0);
        resetb = 1'b1;
        cfg_en = 1'b1;
        line_idle(20);

        // Character, parity and framing vectors, each popped straight after arrival.
        for (int i = 0; i < 8; i++) begin
            cfg_parity = vecs[i].pmode;
            sb_q.push_back({vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].data});
            send_frame(vecs[i].data, vecs[i].pmode, vecs[i].pbit, vecs[i].stop, 1'b1, 1'b0, -1, -1);
            check("vec_level_one", 32'(fifo_level), 32'd1);
            line_idle(20);
            pop_check("vec_head");
            check("vec_level_zero", 32'(fifo_level), 32'd0);
        end

        // Framing error followed by a 40-bit break.
        cfg_parity = PAR_NONE;
        sb_q.push_back({1'b0, 1'b1, 8'h5A});
        send_frame(8'h5A, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        repeat (640) begin
            @(negedge clk);
            rx = 1'b0;
        end
        check("break_level", 32'(fifo_level), 32'd1);
        line_idle(32);
        sb_q.push_back({1'b0, 1'b0, 8'hC3});
        send_frame(8'hC3, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
        line_idle(20);
        check("after_break_level", 32'(fifo_level), 32'd2);
        pop_check("break_fe_head");
        pop_check("after_break_head");

        // Four-clock glitch must not produce a character.
        repeat (4) begin
            @(negedge clk);
            rx = 1'b0;
        end
        line_idle(40);
        check("glitch_level", 32'(fifo_level), 32'd0);
        check("glitch_valid", 32'(m.valid), 32'd0);
        sb_q.push_back({1'b0, 1'b0, 8'h96});
        send_frame(8'h96, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
        line_idle(10);
        pop_check("post_glitch_head");

        // Overrun: nine characters into eight entries.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb_q.push_back({2'b00, 8'(i)});
            send_frame(8'(i), PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
            line_idle(4);
        end
        check("ovr_level", 32'(fifo_level), 32'd8);
        check("ovr_set", 32'(ovr_flag), 32'd1);
        for (int i = 0; i < 8; i++) pop_check("ovr_drain");
        check("ovr_sticky", 32'(ovr_flag), 32'd1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(ovr_flag), 32'd0);

        // Full FIFO with a pop coinciding with the push: no overrun.
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back({2'b00, 8'(8'h10 + i)});
            send_frame(8'(8'h10 + i), PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
            line_idle(4);
        end
        sb_q.push_back({2'b00, 8'h18});
        send_frame(8'h18, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b1, -1, -1);
        line_idle(4);
        check("pushpop_ovr", 32'(ovr_flag), 32'd0);
        check("pushpop_level", 32'(fifo_level), 32'd8);
        for (int i = 0; i < 8; i++) pop_check("pushpop_drain");

        // Reset during data bit 3 empties the FIFO and discards the frame.
        sb_q.push_back({2'b00, 8'h77});
        send_frame(8'h77, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
        line_idle(4);
        send_frame(8'hE1, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 16 * 4 + 8, -1);
        sb_q.delete();
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_valid", 32'(m.valid), 32'd0);
        check("midrst_data", 32'(m.data), 32'd0);
        check("midrst_ovr", 32'(ovr_flag), 32'd0);
        line_idle(20);
        sb_q.push_back({2'b00, 8'h3C});
        send_frame(8'h3C, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
        line_idle(10);
        pop_check("post_rst_head");

        // Receiver disabled mid-frame: frame aborted, nothing pushed.
        send_frame(8'h55, PAR_NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1, 80);
        line_idle(4);
        cfg_en = 1'b1;
        line_idle(20);
        check("en_drop_level", 32'(fifo_level), 32'd0);
        sb_q.push_back({2'b00, 8'h42});
        send_frame(8'h42, PAR_NONE, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
        line_idle(10);
        pop_check("post_en_head");
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
